load_store_unit: RTL and testbench

- Initiator-side front end for the word-addressed data memory.
- Accepts core load/store requests in RISC-V byte, halfword and word formats and issues word reads and writes over the memory's data port.
- Sub-word stores are done as read-modify-write sequences; loads are aligned and sign- or zero-extended.
- Sits between execute stage and memory; one request outstanding at a time.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core request/response channel plus word-wide data-memory port of the load/store unit.
// The unit uses the slave modport; the core and memory together sit on the master side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write, mem_wdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end over a word memory; resp after 1 (error), 2 (load/SW), 3 (SB/SH) cycles.
// One request in flight: req_ready only in IDLE, response held until resp_ready.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  byte_off_q, byte_off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        f3_ok, misaligned, out_of_range, req_err;
  logic [31:0] byte_shift, half_shift, load_val, merged;

  always_comb begin
    f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_store;
      default:                f3_ok = 1'b0;
    endcase
    misaligned   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    out_of_range = {1'b0, bus.req_addr} >= MEM_BYTES;
    req_err      = !f3_ok || misaligned || out_of_range;
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    byte_shift = bus.mem_rdata >> {byte_off_q, 3'b000};
    half_shift = bus.mem_rdata >> {byte_off_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_val = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_val = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_val = {24'h0, byte_shift[7:0]};
      3'b101:  load_val = {16'h0, half_shift[15:0]};
      default: load_val = bus.mem_rdata;
    endcase
    merged = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) merged[{byte_off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                        merged[{byte_off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    byte_off_d  = byte_off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d    = bus.req_store;
          funct3_d   = bus.req_funct3;
          byte_off_d = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata[15:0];
          if (req_err) begin
            // Memory port keeps its previous values for rejected requests.
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (bus.req_store && bus.req_funct3 == 3'b010) begin
            state_d     = WRITE;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
          end else begin
            state_d    = READ;
            mem_addr_d = bus.req_addr;
          end
        end
      end
      READ: begin
        if (store_q) begin
          state_d     = WRITE;
          mem_wdata_d = merged;
        end else begin
          state_d = RESP;
          rdata_d = load_val;
          err_d   = 1'b0;
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      byte_off_q  <= 2'b00;
      wdata_q     <= 16'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      byte_off_q  <= byte_off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Write strobe is a pure state decode so reset removes it within the cycle.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_write  = (state_q == WRITE);
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, response backpressure, randomized traffic vs a byte-array model,
// and reset asserted in the middle of a store write.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit #(.MEM_WORDS(1024)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [0:1023];
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
  always @(negedge clk) if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called with inputs idle, 1 time unit after a posedge.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output int nwr,
                        output logic [31:0] mwd);
    int w;
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    w = 0;
    while (!bus.req_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; nwr = 0; mwd = 32'h0;
    while (!bus.resp_valid && lat < 20) begin
      if (bus.mem_write) begin nwr++; mwd = bus.mem_wdata; end
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) lat = 99;
    rd = bus.resp_rdata; er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwr;
    logic [31:0] mwd;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  rb [0:4095];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] rd, mwd, exp_v, exp_mwd, mask;
    logic        er, exp_er, legal;
    int          lat, nwr, size, exp_lat, exp_nwr, mism;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h11223344;
    mem[32'h200 >> 2] = 32'h80FF7F01;
    mem[1023]         = 32'hCAFEF00D;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    //            st    f3      addr         wdata         rdata         err  lat nwr mwdata
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'h11223344, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'h203,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 32'h203,  32'h0,        32'h00000080, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h202,  32'h0,        32'hFFFF80FF, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b101, 32'h202,  32'h0,        32'h000080FF, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'h200,  32'h0,        32'h00000001, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h101,  32'hDEADBEAB, 32'h0,        1'b0, 3, 1, 32'h1122AB44});
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'h1122AB44, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h100,  32'h11223344, 32'h0,        1'b0, 2, 1, 32'h11223344});
    tbl.push_back('{1'b1, 3'b001, 32'h102,  32'h00005566, 32'h0,        1'b0, 3, 1, 32'h55663344});
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'h55663344, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h101,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h102,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b100, 32'h100,  32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'h55663344, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 32'h0});

    foreach (tbl[i]) begin
      do_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat, nwr, mwd);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].er});
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_writes", i), nwr, tbl[i].nwr);
      if (tbl[i].nwr > 0) chk($sformatf("vec%0d_mem_wdata", i), mwd, tbl[i].mwd);
    end

    // Response backpressure: LW held for 5 cycles with resp_ready low.
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_latency_valid", {31'h0, bus.resp_valid}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", {31'h0, bus.resp_valid}, 32'h1);
      chk("bp_hold_rdata", bus.resp_rdata, 32'h55663344);
      chk("bp_hold_err_ready", {30'h0, bus.resp_err, bus.req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("bp_release_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("bp_release_valid", {31'h0, bus.resp_valid}, 32'h0);

    // Randomized traffic against a byte-addressed model of memory.
    for (int w = 0; w < 1024; w++)
      for (int b = 0; b < 4; b++) rb[w*4 + b] = mem[w][8*b +: 8];
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 15))
        0:       a = 32'h1000 + $urandom_range(0, 15);
        1:       a = $urandom;
        default: a = $urandom_range(0, 4095);
      endcase
      size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      legal = (f3[1:0] != 2'b11) && (st ? !f3[2] : (f3 != 3'b110));
      exp_er = !legal || (a % size != 0) || (a >= 32'd4096);
      exp_v = 32'h0; exp_nwr = 0; exp_mwd = 32'h0;
      if (exp_er) exp_lat = 1;
      else if (!st) begin
        exp_lat = 2;
        for (int k = 0; k < size; k++) exp_v |= 32'(rb[a + k]) << (8*k);
        mask = (size == 4) ? 32'h0 : ~((32'h1 << (8*size)) - 1);
        if (!f3[2] && size < 4 && exp_v[8*size-1]) exp_v |= mask;
      end else begin
        exp_lat = (size == 4) ? 2 : 3;
        exp_nwr = 1;
        for (int k = 0; k < size; k++) rb[a + k] = wd[8*k +: 8];
        for (int k = 0; k < 4; k++) exp_mwd[8*k +: 8] = rb[(a & ~32'h3) + k];
      end
      do_req(st, f3, a, wd, rd, er, lat, nwr, mwd);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_v);
      chk($sformatf("rnd%0d_err", n), {31'h0, er}, {31'h0, exp_er});
      chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
      chk($sformatf("rnd%0d_writes", n), nwr, exp_nwr);
      if (exp_nwr > 0) chk($sformatf("rnd%0d_mem_wdata", n), mwd, exp_mwd);
    end
    mism = 0;
    for (int w = 0; w < 1024; w++)
      if (mem[w] !== {rb[w*4+3], rb[w*4+2], rb[w*4+1], rb[w*4]}) mism++;
    chk("rnd_final_mem_mismatch_words", mism, 0);

    // Reset asserted while an SH sits in WRITE.
    mem[32'h300 >> 2] = 32'hA1B2C3D4;
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h302; bus.req_wdata = 32'h00001234;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_write", {31'h0, bus.mem_write}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rstw_mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("rstw_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rstw_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
    chk("rstw_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rstw_mem_addr", bus.mem_addr, 32'h0);
    chk("rstw_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    chk("rstw_word_unchanged", mem[32'h300 >> 2], 32'hA1B2C3D4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstw_release_ready", {31'h0, bus.req_ready}, 32'h1);
    do_req(1'b0, 3'b010, 32'h300, 32'h0, rd, er, lat, nwr, mwd);
    chk("rstw_lw_rdata", rd, 32'hA1B2C3D4);
    chk("rstw_lw_err", {31'h0, er}, 32'h0);
    chk("rstw_lw_latency", lat, 2);
    chk("rstw_lw_writes", nwr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
